// File: rtl/vga_plot_sink.sv
// vga_plot_sink
// Receives the (X, Y, Colour, Plot) pixel-write stream from the drawing
// blocks and stores it in a 160x120, 3-bit framebuffer. The framebuffer is
// scanned out as a 640x480 VGA raster with each stored pixel shown as a
// 4x4 block.
//
// Ports
//   iClock       single clock; all flops on the rising edge
//   iReset       synchronous, active-high reset
//   iX, iY       plot coordinates (column 0..159, row 0..119 are in range)
//   iColour      plot colour {R,G,B}
//   iPlot        write strobe, one write per clock while high
//   oColour      scanout colour, forced to 0 while blanked or not ready
//   oHSync       horizontal sync, active-low
//   oVSync       vertical sync, active-low
//   oBlank       high outside the visible region
//   oFrameStart  one-clock pulse on the first clock of pixel (0,0)
//   oReady       high once the post-reset clear has finished
//   oDropCount   saturating count of rejected out-of-range plots
module vga_plot_sink #(
   parameter int X_SCREENSIZE     = 160,
   parameter int Y_SCREENSIZE     = 120,
   parameter int CLOCKS_PER_PIXEL = 2,
   parameter int H_VISIBLE        = 640,
   parameter int H_FRONT          = 16,
   parameter int H_SYNC           = 96,
   parameter int H_BACK           = 48,
   parameter int V_VISIBLE        = 480,
   parameter int V_FRONT          = 10,
   parameter int V_SYNC           = 2,
   parameter int V_BACK           = 33
) (
   input  logic       iClock,
   input  logic       iReset,
   input  logic [7:0] iX,
   input  logic [6:0] iY,
   input  logic [2:0] iColour,
   input  logic       iPlot,
   output logic [2:0] oColour,
   output logic       oHSync,
   output logic       oVSync,
   output logic       oBlank,
   output logic       oFrameStart,
   output logic       oReady,
   output logic [7:0] oDropCount
);

   localparam int FB_WORDS = X_SCREENSIZE * Y_SCREENSIZE;
   localparam int DIV_W    = (CLOCKS_PER_PIXEL > 1) ? $clog2(CLOCKS_PER_PIXEL) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCKS_PER_PIXEL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   // Terminal count is one past the last address: the clock spent sitting
   // on it is the hand-over into S_RUN, so ready lands one edge after the
   // final clear write.
   localparam logic [14:0] CLR_END = 15'(FB_WORDS);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   typedef struct packed {
      logic vis;
      logic hs_n;
      logic vs_n;
      logic fs;
   } scan_t;

   localparam scan_t SCAN_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

   // 160-wide row stride as shifts; 15 bits holds every 8-bit x / 7-bit y
   // combination without wrap.
   function automatic logic [14:0] f_addr(input logic [7:0] x, input logic [6:0] y);
      return {1'b0, y, 7'd0} + {3'd0, y, 5'd0} + {7'd0, x};
   endfunction

   // ---------------- write side ----------------
   state_t      r_state, w_state_nxt;
   logic [14:0] r_clr;
   logic [7:0]  r_drop;
   logic        w_we;
   logic [14:0] w_waddr;
   logic [2:0]  w_wdata;
   logic        w_drop_inc;
   logic        w_in_range;
   logic        w_ready;

   logic [2:0]  r_mem [FB_WORDS];

   assign w_in_range = (iX < 8'(X_SCREENSIZE)) && (iY < 7'(Y_SCREENSIZE));
   assign w_ready    = (r_state == S_RUN);

   always_ff @(posedge iClock) begin
      if (iReset) r_state <= S_CLEAR;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_waddr     = r_clr;
      w_wdata     = '0;
      w_drop_inc  = 1'b0;
      unique case (r_state)
         S_CLEAR: begin
            if (r_clr == CLR_END) w_state_nxt = S_RUN;
            else                  w_we        = 1'b1;
         end
         S_RUN: begin
            if (iPlot) begin
               if (w_in_range) begin
                  w_we    = 1'b1;
                  w_waddr = f_addr(iX, iY);
                  w_wdata = iColour;
               end else begin
                  w_drop_inc = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge iClock) begin
      if (iReset)                                    r_clr <= '0;
      else if (r_state == S_CLEAR && r_clr != CLR_END) r_clr <= r_clr + 15'd1;
   end

   always_ff @(posedge iClock) begin
      if (iReset)                          r_drop <= '0;
      else if (w_drop_inc && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
   end

   always_ff @(posedge iClock) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   // ---------------- scanout ----------------
   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_h, r_v;
   logic             w_pix;
   scan_t            w_scan, r_s1;
   logic [14:0]      r_s1_addr;
   logic [2:0]       r_colour;
   logic             r_hs_n, r_vs_n, r_blank, r_fs;

   assign w_pix = (r_div == DIV_LAST);

   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_div <= '0;
         r_h   <= '0;
         r_v   <= '0;
      end else begin
         r_div <= w_pix ? '0 : r_div + 1'b1;
         if (w_pix) begin
            if (r_h == H_LAST) begin
               r_h <= '0;
               r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
            end else begin
               r_h <= r_h + 10'd1;
            end
         end
      end
   end

   always_comb begin
      w_scan      = SCAN_IDLE;
      w_scan.vis  = (r_h < H_VIS) && (r_v < V_VIS);
      w_scan.hs_n = !((r_h >= HS_BEG) && (r_h < HS_END));
      w_scan.vs_n = !((r_v >= VS_BEG) && (r_v < VS_END));
      // Only the first divider phase of (0,0), so the pulse is one clock wide.
      w_scan.fs   = (r_h == 10'd0) && (r_v == 10'd0) && (r_div == '0);
   end

   // Stage 1: address and raster terms.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_s1      <= SCAN_IDLE;
         r_s1_addr <= '0;
      end else begin
         r_s1      <= w_scan;
         r_s1_addr <= w_scan.vis ? f_addr(r_h[9:2], r_v[8:2]) : '0;
      end
   end

   // Stage 2: memory data plus delayed raster terms. The read sits beside
   // any write to the same address on this edge, so it returns the old word.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_colour <= '0;
         r_hs_n   <= 1'b1;
         r_vs_n   <= 1'b1;
         r_blank  <= 1'b1;
         r_fs     <= 1'b0;
      end else begin
         r_colour <= (r_s1.vis && w_ready) ? r_mem[r_s1_addr] : '0;
         r_hs_n   <= r_s1.hs_n;
         r_vs_n   <= r_s1.vs_n;
         r_blank  <= !r_s1.vis;
         r_fs     <= r_s1.fs;
      end
   end

   assign oColour     = r_colour;
   assign oHSync      = r_hs_n;
   assign oVSync      = r_vs_n;
   assign oBlank      = r_blank;
   assign oFrameStart = r_fs;
   assign oReady      = w_ready;
   assign oDropCount  = r_drop;

endmodule

// File: doc/vga_plot_sink.md
# vga_plot_sink

Receiving end of the box-drawing pixel interface: accepts the (X, Y, Colour, Plot) write stream produced by the animation blocks and stores it in a 160x120, 3-bit framebuffer. It also reads the framebuffer back out as a 640x480 VGA raster with 4x pixel replication, driving sync, blank and colour pins. It sits between the drawing FSM/datapath and the board's VGA DAC and replaces the vendor adapter.

## Interface
- X_SCREENSIZE, 160, framebuffer width in pixels.
- Y_SCREENSIZE, 120, framebuffer height in pixels.
- CLOCKS_PER_PIXEL, 2, iClock cycles per VGA pixel period. 50 MHz gives a 25 MHz pixel rate.
- H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48. Horizontal timing, in pixel periods.
- V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33. Vertical timing, in lines.
- Scale is fixed at 4 (H_VISIBLE/X_SCREENSIZE).

Ports:
- iClock  in  1  the single clock. Every flop is on its rising edge.
- iReset  in  1  reset, synchronous and active-high.
- iX  in  8  plot column.
- iY  in  7  plot row.
- iColour  in  3  plot colour {R,G,B}.
- iPlot  in  1  write strobe. Sampled every clock; one write per clock it is high.
- oColour  out  3  scanout colour {R,G,B}.
- oHSync  out  1  horizontal sync, active-low.
- oVSync  out  1  vertical sync, active-low.
- oBlank  out  1  high outside the visible region.
- oFrameStart  out  1  one-clock pulse aligned with output pixel (0,0).
- oReady  out  1  high once the post-reset clear has finished.
- oDropCount  out  8  saturating count of rejected out-of-range plots.

## Operation
- Memory: X_SCREENSIZE*Y_SCREENSIZE words of 3 bits, 19200 total.
  - One write port and one read port, both synchronous.
  - Read has 1-clock latency.
- Address arithmetic: addr = (y<<7) + (y<<5) + x, 15 bits, with no truncation.
- Write-side FSM states:
  - S_CLEAR: entered on reset. Clear counter c runs from 0 to 19199. Each clock writes 3'b000 to address c. iPlot is ignored and not counted. At c == 19199, go to S_RUN on the next clock.
  - S_RUN: oReady = 1. When iPlot = 1:
    - If iX < X_SCREENSIZE and iY < Y_SCREENSIZE, write iColour to addr(iX, iY).
    - Otherwise make no write and increment oDropCount, saturating at 255.
- Scanout:
  - A pixel-enable divider pulses once every CLOCKS_PER_PIXEL clocks.
  - h counts 0..799 and v counts 0..524, advancing on the pulse. h wraps to 0, and v increments when h wraps. v wraps to 0 after 524.
  - Visible region: h < 640 and v < 480. Read address = addr(h>>2, v>>2).
  - HSync is low for h in 656..751. VSync is low for v in 490..491.
  - oColour is 0 whenever blanked or whenever oReady = 0.
- Same-address write and read in one clock: the read returns the old data (read-before-write). The new value appears on the next scan of that pixel.
- Scanout runs during S_CLEAR.

## Timing
- Reset values (the clock after iReset = 1):
  - oColour = 0, oHSync = 1, oVSync = 1, oBlank = 1.
  - oFrameStart = 0, oReady = 0, oDropCount = 0.
  - h = v = 0, divider = 0, clear counter = 0, state = S_CLEAR.
- Reset mid-frame or mid-clear: every counter restarts and the clear re-runs in full. Memory contents before the clear completes are don't-care, but oColour is forced to 0.
- Clear duration: exactly 19200 clocks.
  - The first clock after iReset falls writes address 0.
  - oReady rises on the 19201st rising edge after iReset deasserts.
- Plot write latency: a plot accepted at edge N is readable by a scanout read issued at edge N+1 or later.
- oDropCount updates 1 clock after the offending iPlot.
- Scanout pipeline, 2 clocks from counter state to pins:
  - Stage 1 registers the address, blank and sync terms.
  - Stage 2 registers the memory data, with delayed blank and sync.
  - All outputs are registered and mutually aligned.
- oFrameStart is high for exactly one clock per frame, on the clock oBlank falls for h = 0, v = 0.
- Frame period: 800*525*CLOCKS_PER_PIXEL clocks (840000 at the defaults). Line period: 1600 clocks.

## Test plan
- Clear: assert iReset for 3 clocks, then release. oReady stays 0 for 19200 clocks and rises on clock 19201. During the clear, iPlot = 1 at (0,0) with colour 3'b111 is ignored, and the pixel reads 0 afterwards.
- Plot and scan: after oReady, plot (5,7) with colour 3'b101.
  - Next frame: oColour = 101 exactly for h 20..23 on lines 28..31.
  - The pixels at (19,28) and (24,28) read 000.
- Range check: plot (160,0) then (0,120), both with colour 3'b111. oDropCount reads 2 and all pixels stay 000. Then 300 consecutive bad plots: oDropCount saturates at 255.
- Sync timing: measure the default raster.
  - oHSync low for 192 clocks within a 1600-clock line.
  - oVSync low for 3200 clocks within an 840000-clock frame.
  - oBlank is 0 for 1280 clocks per visible line.
  - oFrameStart pulses every 840000 clocks.
- Read-during-write: plot colour 3'b010 to the pixel being read on the same clock. The current frame shows the old value and the next frame shows 010.
- Reset mid-frame: assert iReset at v = 200.
  - oHSync, oVSync and oBlank return to 1 and oColour to 0.
  - oDropCount clears and oReady drops.
  - The clear re-runs in 19200 clocks, and previously plotted pixels read 000.
